// File: rtl/booth_pkg.sv
// Shared encodings and helpers for the radix-4 Booth multiply/accumulate core.
package booth_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MAC  = 2'b01,
    OP_LOAD = 2'b10,
    OP_MSUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_ACC  = 2'b10,
    S_HOLD = 2'b11
  } state_e;

  // One-hot magnitude select plus sign for a single Booth digit.
  typedef struct packed {
    logic zero;
    logic neg;
    logic x1;
    logic x2;
    logic x3;
  } booth_ctl_t;

  // Window is {b[2i+1], b[2i], b[2i-1]}. A 3-bit window only ever yields
  // digits in -2..+2, so x3 is never raised here; the 3A path stays
  // available to the step for wider-window decoders.
  function automatic booth_ctl_t booth_decode(input logic [2:0] win);
    booth_ctl_t c;
    c = '0;
    case (win)
      3'b000, 3'b111: c.zero = 1'b1;
      3'b001, 3'b010: c.x1   = 1'b1;
      3'b011:         c.x2   = 1'b1;
      3'b100:         begin c.x2 = 1'b1; c.neg = 1'b1; end
      default:        begin c.x1 = 1'b1; c.neg = 1'b1; end
    endcase
    return c;
  endfunction

  // Extension bit for an operand: its MSB when treated as signed, else 0.
  function automatic logic ext_bit(input logic msb, input logic is_signed);
    return msb & is_signed;
  endfunction

endpackage

// File: rtl/booth_r4_step.sv
// One radix-4 Booth step: adds or subtracts 0/A/2A/3A to the partial high slice.
module booth_r4_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH+2:0] part,
  input  booth_ctl_t       ctl,
  input  logic [WIDTH+2:0] a,
  input  logic [WIDTH+2:0] a3,
  output logic [WIDTH+2:0] sum
);

  logic [WIDTH+2:0] sel;

  // Select the multiple of A, then add or subtract it from the partial sum.
  always_comb begin
    sel = '0;
    if (ctl.zero)    sel = '0;
    else if (ctl.x1) sel = a;
    else if (ctl.x2) sel = a << 1;
    else if (ctl.x3) sel = a3;
    sum = ctl.neg ? (part - sel) : (part + sel);
  end

endmodule

// File: rtl/booth_mult_r4_mac.sv
// Sequential radix-4 Booth multiplier with signed accumulator and sticky overflow.
module booth_mult_r4_mac
  import booth_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_GUARD = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             multiplicand,
  input  logic [WIDTH-1:0]             multiplier,
  input  logic [1:0]                   sign_mode,
  input  logic [1:0]                   op,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*WIDTH-1:0]           product,
  output logic [2*WIDTH+ACC_GUARD-1:0] result,
  output logic                         ovf
);

  localparam int N     = WIDTH / 2;
  localparam int ACC_W = 2 * WIDTH + ACC_GUARD;
  localparam int HW    = WIDTH + 3;           // high slice holds up to 3A
  localparam int PW    = 2 * WIDTH + 3;       // full shift register width
  localparam int XW    = (PW > ACC_W) ? PW : ACC_W;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_mult_r4_mac: WIDTH must be even and >= 4");
  end
  if (ACC_GUARD < 1) begin : g_bad_guard
    $error("booth_mult_r4_mac: ACC_GUARD must be >= 1");
  end

  state_e                  state, state_nxt;
  logic [N-1:0]            cnt;
  logic [HW-1:0]           hi, a_r, a3_r, a_in, a3_in, step_sum;
  logic [WIDTH-1:0]        lo;
  logic                    prev, corr, accept, ext_a;
  op_e                     op_r;
  booth_ctl_t              ctl;
  logic signed [ACC_W-1:0] acc, p_acc, acc_add, acc_sub;
  logic signed [PW-1:0]    p_booth;
  logic signed [HW-1:0]    a_s;
  logic signed [XW-1:0]    p_wide;
  logic                    add_ovf, sub_ovf;

  assign accept = in_valid & in_ready;
  assign ext_a  = ext_bit(multiplicand[WIDTH-1], sign_mode[1]);
  assign a_in   = {{3{ext_a}}, multiplicand};
  assign a3_in  = a_in + (a_in << 1);
  assign ctl    = booth_decode({lo[1:0], prev});

  booth_r4_step #(.WIDTH(WIDTH)) u_step (
    .part (hi),
    .ctl  (ctl),
    .a    (a_r),
    .a3   (a3_r),
    .sum  (step_sum)
  );

  // Next-state and handshake outputs; in_ready follows out_ready in HOLD.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_RUN;
      end
      S_RUN:  if (cnt[N-1]) state_nxt = S_ACC;
      S_ACC:  state_nxt = S_HOLD;
      S_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? S_RUN : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Booth runs on the multiplier as signed; an unsigned multiplier with MSB
  // set is repaired by adding A<<WIDTH once the iterations are done.
  always_comb begin
    p_booth = {hi, lo};
    a_s     = a_r;
    p_wide  = XW'(p_booth);
    if (corr) p_wide = p_wide + (XW'(a_s) <<< WIDTH);
    p_acc   = p_wide[ACC_W-1:0];
    acc_add = acc + p_acc;
    acc_sub = acc - p_acc;
    add_ovf = (acc[ACC_W-1] == p_acc[ACC_W-1]) && (acc_add[ACC_W-1] != acc[ACC_W-1]);
    sub_ovf = (acc[ACC_W-1] != p_acc[ACC_W-1]) && (acc_sub[ACC_W-1] != acc[ACC_W-1]);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, Booth iteration, and accumulate/output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      prev    <= 1'b0;
      a_r     <= '0;
      a3_r    <= '0;
      corr    <= 1'b0;
      op_r    <= OP_MUL;
      acc     <= '0;
      ovf     <= 1'b0;
      product <= '0;
      result  <= '0;
    end else if (accept) begin
      a_r  <= a_in;
      a3_r <= a3_in;
      hi   <= '0;
      lo   <= multiplier;
      prev <= 1'b0;
      cnt  <= N'(1);
      corr <= ~sign_mode[0] & multiplier[WIDTH-1];
      op_r <= op_e'(op);
    end else if (state == S_RUN) begin
      hi   <= {{2{step_sum[HW-1]}}, step_sum[HW-1:2]};
      lo   <= {step_sum[1:0], lo[WIDTH-1:2]};
      prev <= lo[1];
      cnt  <= cnt << 1;
    end else if (state == S_ACC) begin
      product <= p_acc[2*WIDTH-1:0];
      case (op_r)
        OP_LOAD: begin acc <= p_acc;   result <= p_acc;   ovf <= 1'b0;          end
        OP_MAC:  begin acc <= acc_add; result <= acc_add; ovf <= ovf | add_ovf; end
        OP_MSUB: begin acc <= acc_sub; result <= acc_sub; ovf <= ovf | sub_ovf; end
        default: result <= p_acc;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_r4_mac.sv
// Bench: directed WIDTH=8 vectors and sequences, randomized WIDTH=16 vs model.
module tb_booth_mult_r4_mac;

  localparam logic [1:0] MUL = 2'b00, MAC = 2'b01, LOAD = 2'b10, MSUB = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8_n, iv8, ir8, ov8, or8, ovf8;
  logic [7:0]  a8, b8;
  logic [1:0]  sm8, op8;
  logic [15:0] prod8;
  logic [16:0] res8;

  logic        rst16_n, iv16, ir16, ov16, or16, ovf16;
  logic [15:0] a16, b16;
  logic [1:0]  sm16, op16;
  logic [31:0] prod16;
  logic [39:0] res16;

  booth_mult_r4_mac #(.WIDTH(8), .ACC_GUARD(1)) dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8),
    .multiplicand(a8), .multiplier(b8), .sign_mode(sm8), .op(op8),
    .out_valid(ov8), .out_ready(or8), .product(prod8), .result(res8), .ovf(ovf8)
  );

  booth_mult_r4_mac #(.WIDTH(16), .ACC_GUARD(8)) dut16 (
    .clk(clk), .rst_n(rst16_n), .in_valid(iv16), .in_ready(ir16),
    .multiplicand(a16), .multiplier(b16), .sign_mode(sm16), .op(op16),
    .out_valid(ov16), .out_ready(or16), .product(prod16), .result(res16), .ovf(ovf16)
  );

  int total = 0, bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic [1:0] sm, op;
    longint     prod, res;
    logic       ovf;
  } vec_t;

  vec_t tbl[10];

  // Issue one WIDTH=8 request and count edges until out_valid (bounded).
  task automatic run8(input vec_t v, output int lat);
    @(negedge clk);
    a8 = v.a; b8 = v.b; sm8 = v.sm; op8 = v.op; iv8 = 1'b1; or8 = 1'b0;
    @(posedge clk); #1;
    iv8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 2'($urandom); op8 = 2'($urandom);
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic rel8();
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  task automatic check8(input string nm, input vec_t v, input int lat);
    chk({nm, "_lat"},  lat, 5);
    chk({nm, "_prod"}, longint'(prod8), v.prod);
    chk({nm, "_res"},  longint'($signed(res8)), v.res);
    chk({nm, "_ovf"},  longint'(ovf8), longint'(v.ovf));
  endtask

  function automatic vec_t mk(input logic [7:0] a, b, input logic [1:0] sm, op,
                              input longint prod, res, input logic o);
    vec_t v;
    v.a = a; v.b = b; v.sm = sm; v.op = op; v.prod = prod; v.res = res; v.ovf = o;
    return v;
  endfunction

  // Reference model for WIDTH=16 / ACC_W=40, plain integer arithmetic.
  typedef struct { longint p; longint r; logic o; } exp_t;
  exp_t   q[$];
  longint macc = 0;
  logic   movf = 1'b0;

  function automatic longint wrap40(input longint x);
    return (x <<< 24) >>> 24;
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic model_accept(input logic [15:0] a, b, input logic [1:0] sm, op);
    longint ea, eb, p, t;
    exp_t   e;
    ea = sm[1] ? longint'($signed(a)) : longint'(a);
    eb = sm[0] ? longint'($signed(b)) : longint'(b);
    p  = ea * eb;
    e.r = p;
    case (op)
      LOAD: begin macc = p; movf = 1'b0; end
      MAC:  begin t = macc + p; if (wrap40(t) != t) movf = 1'b1; macc = wrap40(t); e.r = macc; end
      MSUB: begin t = macc - p; if (wrap40(t) != t) movf = 1'b1; macc = wrap40(t); e.r = macc; end
      default: ;
    endcase
    e.p = p & 64'hFFFF_FFFF;
    e.o = movf;
    q.push_back(e);
  endtask

  initial begin
    int   lat, issued, done, cyc;
    logic seen, fin, fout;
    vec_t v;

    tbl[0] = mk(8'h80, 8'h80, 2'b11, MUL,  64'h4000, 16384,  1'b0);
    tbl[1] = mk(8'h7F, 8'h80, 2'b11, MUL,  64'hC080, -16256, 1'b0);
    tbl[2] = mk(8'hFF, 8'hFF, 2'b00, MUL,  64'hFE01, 65025,  1'b0);
    tbl[3] = mk(8'hFF, 8'hFF, 2'b10, MUL,  64'hFF01, -255,   1'b0);
    tbl[4] = mk(8'hFF, 8'hFF, 2'b00, LOAD, 64'hFE01, 65025,  1'b0);
    tbl[5] = mk(8'hFF, 8'hFF, 2'b00, MAC,  64'hFE01, -1022,  1'b1);
    tbl[6] = mk(8'h02, 8'h03, 2'b00, MUL,  64'h0006, 6,      1'b1);
    tbl[7] = mk(8'h00, 8'h00, 2'b00, LOAD, 64'h0000, 0,      1'b0);
    tbl[8] = mk(8'h01, 8'h05, 2'b11, MSUB, 64'h0005, -5,     1'b0);
    tbl[9] = mk(8'hFF, 8'h01, 2'b11, MSUB, 64'hFFFF, -4,     1'b0);

    rst8_n = 1'b0; rst16_n = 1'b0;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0; sm8 = 0; op8 = 0;
    iv16 = 0; or16 = 0; a16 = 0; b16 = 0; sm16 = 0; op16 = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  longint'(ir8),   1);
    chk("rst_out_valid", longint'(ov8),   0);
    chk("rst_product",   longint'(prod8), 0);
    chk("rst_result",    longint'(res8),  0);
    chk("rst_ovf",       longint'(ovf8),  0);
    chk("rst16_result",  longint'(res16), 0);
    rst8_n = 1'b1; rst16_n = 1'b1;

    // Directed WIDTH=8 table.
    for (int i = 0; i < 10; i++) begin
      run8(tbl[i], lat);
      check8($sformatf("vec%0d", i), tbl[i], lat);
      rel8();
    end

    // Backpressure: stall 10 cycles, then accept a new request on the release edge.
    run8(mk(8'h0C, 8'h0D, 2'b00, MUL, 156, 156, 1'b0), lat);
    chk("bp_lat", lat, 5);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      iv8 = 1'b1; a8 = 8'd3; b8 = 8'd5; sm8 = 2'b00; op8 = MUL;
      chk("bp_valid",  longint'(ov8),   1);
      chk("bp_prod",   longint'(prod8), 156);
      chk("bp_result", longint'($signed(res8)), 156);
      chk("bp_ready",  longint'(ir8),   0);
    end
    @(negedge clk);
    a8 = 8'd7; b8 = 8'd9; or8 = 1'b1;
    #1 chk("bp_ready_comb", longint'(ir8), 1);
    @(posedge clk); #1;
    iv8 = 1'b0; or8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp2_lat", lat, 5);
    chk("bp2_result", longint'($signed(res8)), 63);
    rel8();

    // Mid-run reset clears everything, including a set ovf and accumulator.
    run8(tbl[4], lat); rel8();
    run8(tbl[5], lat);
    chk("pre_rst_ovf", longint'(ovf8), 1);
    rel8();
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd100; sm8 = 2'b00; op8 = MUL; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst8_n = 1'b0;
    #1;
    chk("arst_valid",  longint'(ov8),   0);
    chk("arst_ready",  longint'(ir8),   1);
    chk("arst_prod",   longint'(prod8), 0);
    chk("arst_result", longint'(res8),  0);
    chk("arst_ovf",    longint'(ovf8),  0);
    @(negedge clk);
    rst8_n = 1'b1;
    v = mk(8'd3, 8'd5, 2'b00, MUL, 15, 15, 1'b0);
    run8(v, lat); check8("post_rst", v, lat); rel8();
    v = mk(8'd1, 8'd1, 2'b00, MAC, 1, 1, 1'b0);
    run8(v, lat); check8("post_rst_mac", v, lat); rel8();

    // Randomized WIDTH=16 run with random out_ready.
    issued = 0; done = 0; cyc = 0; seen = 1'b0;
    while (done < 1000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (ov16 && !seen) begin
        seen = 1'b1;
        chk("r_pending", longint'(q.size() > 0), 1);
        if (q.size() > 0) begin
          chk("r_prod",   longint'(prod16), q[0].p);
          chk("r_result", longint'($signed(res16)), q[0].r);
          chk("r_ovf",    longint'(ovf16), longint'(q[0].o));
        end
      end
      or16 = 1'($urandom_range(0, 1));
      if (!iv16 && issued < 1000) begin
        a16 = pick16(); b16 = pick16();
        sm16 = 2'($urandom); op16 = 2'($urandom);
        iv16 = 1'b1;
      end
      #1;
      fin  = iv16 & ir16;
      fout = ov16 & or16;
      @(posedge clk); #1;
      if (fout) begin
        if (q.size() > 0) void'(q.pop_front());
        seen = 1'b0;
        done++;
      end
      if (fin) begin
        model_accept(a16, b16, sm16, op16);
        iv16 = 1'b0;
        issued++;
      end
    end
    chk("r_done", done, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_mult_r4_mac.md
# booth_mult_r4_mac

Parametrised sequential Booth radix-4 multiplier with a multiply-accumulate option. Generic even operand width, valid/ready handshakes on both sides, and an internal signed accumulator with a sticky overflow flag. Sits between a producer (DSP/control sequencer) and a result consumer that may apply backpressure; replaces the fixed 8-bit Booth core wherever accumulation or stalling is required.

## Interface
- `WIDTH`, 16: operand width; must be even and ≥4, otherwise elaboration error. Iterations N = WIDTH/2.
- `ACC_GUARD`, 8: accumulator guard bits, ≥1. ACC_W = 2*WIDTH + ACC_GUARD.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept a request.
- `multiplicand` in WIDTH: operand A.
- `multiplier` in WIDTH: operand B.
- `sign_mode` in 2: [1]=A signed, [0]=B signed.
- `op` in 2: 00 MUL, 01 MAC, 10 LOAD, 11 MSUB.
- `out_valid` out 1: result valid, held until accepted.
- `out_ready` in 1: consumer accepts the result.
- `product` out 2*WIDTH: low 2*WIDTH bits of the exact product for the current result.
- `result` out ACC_W: signed result per op.
- `ovf` out 1: sticky accumulator overflow flag.

## Operation
- Request and operands are captured on the edge where in_valid & in_ready. sign_mode and op are latched, and inputs may change afterwards.
- Exact product P: signed, 2*WIDTH+1 bits, formed from the operands extended per sign_mode. Sign-extended to ACC_W for accumulation.
- op behaviour:
  - MUL: result = P; acc and ovf unchanged.
  - LOAD: acc ← P, result = P, ovf ← 0.
  - MAC: acc ← acc + P, result = new acc.
  - MSUB: acc ← acc − P, result = new acc.
- MAC/MSUB wrap modulo 2^ACC_W. ovf is set if the signed add or subtract overflows and stays set until LOAD or reset.
- FSM states:
  - IDLE → RUN on accept.
  - RUN: one radix-4 step per cycle (3-bit Booth window, ±0/1/2/3×A with precomputed 3A), 2-bit arithmetic shift. After N steps → ACC.
  - ACC: one cycle; performs the op update and registers product/result → HOLD.
  - HOLD: out_valid=1. On out_ready: → RUN if in_valid, accepting the new request in the same edge; otherwise → IDLE.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). Combinational path from out_ready to in_ready is intentional.
- product/result/ovf are stable throughout HOLD. They keep their last values in IDLE and RUN.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, product=0, result=0, ovf=0, acc=0.
- Latency: out_valid rises N+1 edges after the accept edge. WIDTH=8 gives 5 edges; WIDTH=16 gives 9.
- Throughput with out_ready held high: one result per N+2 cycles.
- in_valid while busy (RUN/ACC or stalled HOLD): ignored, and in_ready=0.
- out_ready while not in HOLD: no effect.
- Reset asserted mid-operation clears everything immediately. No partial result is ever presented.
- out_valid never drops without out_ready (no timeout).

## Structure
- Shared package `booth_pkg`:
  - op encodings (OP_MUL, OP_MAC, OP_LOAD, OP_MSUB) and FSM state encodings;
  - Booth window decode function (window → {zero, neg, x1, x2, x3});
  - operand extension helper.
- Sub-module `booth_r4_step`, combinational: partial accumulator + Booth controls + A + 3A → next accumulator slice, parametrised by WIDTH.
- Top level holds the FSM, iteration counter (one-hot shift, N bits), operand/product shift register, acc, ovf and the output registers.

## Test plan
- WIDTH=8, sign_mode=11, MUL, −128×−128 → after 5 edges: product=0x4000, result=16384. Repeat with 127×−128 → product=0xC080.
- WIDTH=8, sign_mode=00, 255×255 → product=0xFE01, result=65025. sign_mode=10, −1×255 → product=0xFF01, result=−255.
- WIDTH=8, ACC_GUARD=1 (ACC_W=17):
  - LOAD 255×255 → result=65025, ovf=0;
  - MAC 255×255 → result=−1022, ovf=1;
  - MUL 2×3 → result=6, ovf still 1;
  - LOAD 0×0 → ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid, product and result stay stable and in_ready=0. Then out_ready=1 with in_valid=1 → new request accepted in the same edge, next out_valid 5 edges later.
- Reset: assert rst_n=0 two cycles into RUN → all outputs return to reset values asynchronously. A subsequent 3×5 MUL gives 15 with no stale state.
- WIDTH=16, 1000 random (operands, sign_mode, op) triples, out_ready randomly toggled → every result, product and ovf matches the reference model.
